// File: rtl/controlador_display_mux_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment codes are gfedcba, active-low (0 = segment lit).
package controlador_display_mux_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational hex-to-7-segment decoder, gfedcba active-low outputs.
module decodificador_7seg
  import controlador_display_mux_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/controlador_display_mux.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Optional LEADING_ZERO_BLANK_EN: leading zero digits (without dp) keep their anode off.
module controlador_display_mux
  import controlador_display_mux_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_done
);

  localparam int unsigned CntW  = $clog2(DIV);
  localparam int unsigned IdxW  = $clog2(N_DIGITS);
  localparam int unsigned DataW = 4 * N_DIGITS;

  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] SlotLast  = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(N_DIGITS - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DataW-1:0]    act_q, act_d;
  logic [N_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [DataW-1:0]    pend_q, pend_d;
  logic [N_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                frame_end;
  logic [3:0]          dec_nibble;
  logic                dp_sel;
  logic [6:0]          dec_seg;
  logic [N_DIGITS-1:0] lz_hide;

  // Slot counter runs 0..DIV-1 across the whole slot; BLANK covers the first BLANK_CYCLES.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + 1'b1;
    frame_end = 1'b0;
    if (!enable) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          idx_d   = '0;
          cnt_d   = '0;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StShow;
          end
        end
        StShow: begin
          if (cnt_q == SlotLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            if (idx_q == IdxLast) begin
              idx_d     = '0;
              frame_end = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pending buffer absorbs loads; active only changes at frame end or while idle.
  always_comb begin
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    act_d        = act_q;
    act_dp_d     = act_dp_q;
    if (load) begin
      pend_d       = data_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
    if (frame_end || (state_q == StIdle)) begin
      if (load) begin
        act_d    = data_in;
        act_dp_d = dp_in;
      end else if (pend_valid_q) begin
        act_d    = pend_q;
        act_dp_d = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end
  end

  always_comb begin
    dec_nibble = '0;
    dp_sel     = 1'b0;
    for (int k = 0; k < int'(N_DIGITS); k++) begin
      if (idx_d == IdxW'(k)) begin
        dec_nibble = act_d[4*k +: 4];
        dp_sel     = act_dp_d[k];
      end
    end
  end

  decodificador_7seg u_decodificador_7seg (
    .hex_i (dec_nibble),
    .seg_o (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is hidden when it and every digit above it are zero and it has no dp.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_hide    = '0;
    for (int k = int'(N_DIGITS) - 1; k > 0; k--) begin
      zero_above = zero_above && (act_d[4*k +: 4] == 4'h0);
      lz_hide[k] = zero_above && !act_dp_d[k];
    end
  end
`else
  assign lz_hide = '0;
`endif

  // Outputs are computed from next-state values so the registered pins line up with state_q.
  always_comb begin
    seg_d        = SEG_BLANK;
    dp_n_d       = 1'b1;
    an_d         = '1;
    frame_done_d = frame_end || ((state_q == StIdle) && enable);
    if (state_d == StShow) begin
      seg_d  = dec_seg;
      dp_n_d = ~dp_sel;
      for (int k = 0; k < int'(N_DIGITS); k++) begin
        if ((idx_d == IdxW'(k)) && !lz_hide[k]) begin
          an_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      act_q        <= '0;
      act_dp_q     <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      act_q        <= act_d;
      act_dp_q     <= act_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
